post_box_spi_slave: RTL

POST_BOX_SPI_SLAVE -- requirements
Module: post_box_spi_slave

---
 rtl/post_box_pkg.sv | 17 +
 rtl/post_box_sync2.sv | 24 ++
 rtl/post_box_spi_slave.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/post_box_pkg.sv
// Shared constants for the post box SPI slave.
// Optional build macro: POST_SPI_MAGIC_EN selects the status-byte magic nibble.
package post_box_pkg;
  localparam int         SPI_FRAME_BITS = 16;
  localparam int         HAS_BYTE_BIT   = 1;
  localparam int         HAS_SPACE_BIT  = 0;
  localparam logic [3:0] SPI_MAGIC      = 4'hA;
  localparam int         CNT_W          = $clog2(SPI_FRAME_BITS + 1);

  function automatic logic [3:0] status_nibble();
`ifdef POST_SPI_MAGIC_EN
    return SPI_MAGIC;
`else
    return 4'h0;
`endif
  endfunction
endpackage

// File: rtl/post_box_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with selectable reset value.
module post_box_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/post_box_spi_slave.sv
// SPI mode-0 slave exchanging one status byte and one data byte per frame with the post box.
// Optional build macro: POST_SPI_MAGIC_EN puts the magic nibble in the status byte.
module post_box_spi_slave
  import post_box_pkg::*;
(
  input  logic       fpga_clock_48mhz,
  input  logic       reset_n,
  input  logic       fpga_spi_cs,
  input  logic       fpga_spi_sck,
  input  logic       fpga_spi_mosi,
  output logic       fpga_spi_miso,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_pop,
  input  logic       tx_space,
  output logic [7:0] tx_data,
  output logic       tx_push,
  output logic       busy
);
  logic cs_s, sck_s, mosi_s;

  post_box_sync2 #(.RST_VAL(1'b1)) u_sync_cs (
    .clk_i(fpga_clock_48mhz), .rst_ni(reset_n), .d_i(fpga_spi_cs), .q_o(cs_s));
  post_box_sync2 #(.RST_VAL(1'b0)) u_sync_sck (
    .clk_i(fpga_clock_48mhz), .rst_ni(reset_n), .d_i(fpga_spi_sck), .q_o(sck_s));
  post_box_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(fpga_clock_48mhz), .rst_ni(reset_n), .d_i(fpga_spi_mosi), .q_o(mosi_s));

  logic             cs_prev_q, cs_prev_d, sck_prev_q, sck_prev_d;
  logic [1:0]       settle_q, settle_d;
  logic             armed_q, armed_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rxv_q, rxv_d, txs_q, txs_d;
  logic [6:0]       in_sh_q, in_sh_d;
  logic [1:0]       flags_q, flags_d;
  logic [7:0]       cand_q, cand_d;
  logic [15:0]      out_sh_q, out_sh_d;
  logic             miso_q, miso_d, tx_push_q, tx_push_d, rx_pop_q, rx_pop_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic        cs_fall, cs_rise, sck_rise, sck_fall;
  logic [15:0] frame_word;

  // Frames only start once CS has been seen high through a settled synchroniser,
  // so the reset value of the CS chain can never fake a falling edge.
  assign cs_fall    = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise    = busy_q & ~cs_prev_q & cs_s;
  assign sck_rise   = busy_q & ~cs_s & ~sck_prev_q & sck_s;
  assign sck_fall   = busy_q & ~cs_s & sck_prev_q & ~sck_s;
  assign frame_word = {status_nibble(), 2'b00, rx_valid, tx_space,
                       (rx_valid ? rx_data : 8'h00)};

  always_comb begin
    cs_prev_d  = cs_s;
    sck_prev_d = sck_s;
    settle_d   = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d    = armed_q | ((settle_q == 2'd2) & cs_s);
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    rxv_d      = rxv_q;
    txs_d      = txs_q;
    in_sh_d    = in_sh_q;
    flags_d    = flags_q;
    cand_d     = cand_q;
    out_sh_d   = out_sh_q;
    miso_d     = miso_q;
    tx_data_d  = tx_data_q;
    tx_push_d  = 1'b0;
    rx_pop_d   = 1'b0;

    if (cs_fall) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      rxv_d    = rx_valid;
      txs_d    = tx_space;
      miso_d   = frame_word[15];
      out_sh_d = {frame_word[14:0], 1'b0};
    end else if (cs_rise) begin
      busy_d = 1'b0;
      miso_d = 1'b0;
      if (cnt_q == CNT_W'(SPI_FRAME_BITS)) begin
        tx_push_d = flags_q[HAS_BYTE_BIT] & txs_q;
        rx_pop_d  = flags_q[HAS_SPACE_BIT] & rxv_q;
        if (tx_push_d) tx_data_d = cand_q;
      end
    end else begin
      if (sck_rise && (cnt_q != CNT_W'(SPI_FRAME_BITS))) begin
        in_sh_d = {in_sh_q[5:0], mosi_s};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7))  flags_d = {in_sh_q[0], mosi_s};
        if (cnt_q == CNT_W'(15)) cand_d  = {in_sh_q, mosi_s};
      end
      // Zero fill makes MISO read 0 once all 16 bits have been shifted out.
      if (sck_fall) begin
        miso_d   = out_sh_q[15];
        out_sh_d = {out_sh_q[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge fpga_clock_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      settle_q   <= 2'd0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      rxv_q      <= 1'b0;
      txs_q      <= 1'b0;
      in_sh_q    <= '0;
      flags_q    <= '0;
      cand_q     <= '0;
      out_sh_q   <= '0;
      miso_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_push_q  <= 1'b0;
      rx_pop_q   <= 1'b0;
    end else begin
      cs_prev_q  <= cs_prev_d;
      sck_prev_q <= sck_prev_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      rxv_q      <= rxv_d;
      txs_q      <= txs_d;
      in_sh_q    <= in_sh_d;
      flags_q    <= flags_d;
      cand_q     <= cand_d;
      out_sh_q   <= out_sh_d;
      miso_q     <= miso_d;
      tx_data_q  <= tx_data_d;
      tx_push_q  <= tx_push_d;
      rx_pop_q   <= rx_pop_d;
    end
  end

  assign fpga_spi_miso = miso_q;
  assign tx_push       = tx_push_q;
  assign rx_pop        = rx_pop_q;
  assign tx_data       = tx_data_q;
  assign busy          = busy_q;
endmodule
